// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types for the I/D memory port arbiter.
//   state_t  - arbiter FSM encodings (2-bit)
//   sel_t    - port select, I=0 / D=1
//   acc_t    - access latched at grant time
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    ERR_D  = 2'd3
  } state_t;

  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } sel_t;

  localparam int DEFAULT_LATENCY = 2;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wr;
    logic        dump;
    sel_t        sel;
  } acc_t;

endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: 2-way round-robin picker between fetch (I) and memory (D) ports.
//   i_req, d_req  - pending requests
//   last_grant    - port that completed the previous access
//   grant_i/d     - one-hot (or zero) grant
// On a tie the port that was not granted last wins.
module mem_arb_rr
  import mem_port_arbiter_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  sel_t last_grant,
  output logic grant_i,
  output logic grant_d
);

  assign grant_d = d_req & (~i_req | (last_grant == SEL_I));
  assign grant_i = i_req & ~grant_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port 16-bit memory between the fetch
// read port (I) and the memory-stage read/write/dump port (D).
//   clk, rst            - clock, synchronous active-high reset
//   i_req/i_addr        - fetch request, held until i_done
//   i_done/i_rdata      - fetch completion strobe and read data
//   d_req/d_wr/d_dump/d_addr/d_wdata - data request, held until d_done
//   d_done/d_rdata/d_err - data completion, read data, misalignment error
//   i_stall/d_stall     - req & ~done, for pipeline hazard logic
//   mem_*               - memory controls; mem_rdata is combinational
// Each access holds the memory for LATENCY cycles after a one-cycle IDLE
// grant cycle; done is asserted in the last busy cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_done,
  output logic [15:0] i_rdata,
  output logic        i_stall,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic        d_dump,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] d_rdata,
  output logic        d_err,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic        mem_dump,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  sel_t       last_grant;
  acc_t       acc;
  logic       grant_i, grant_d;
  logic       last_cycle;

  mem_arb_rr u_arb (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  assign last_cycle = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= SEL_I;
      acc        <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (grant_d)
            acc <= '{addr: d_addr, wdata: d_wdata, wr: d_wr, dump: d_dump, sel: SEL_D};
          else if (grant_i)
            acc <= '{addr: i_addr, wdata: 16'h0, wr: 1'b0, dump: 1'b0, sel: SEL_I};
        end
        BUSY_I, BUSY_D: begin
          cnt <= cnt + 4'd1;
          if (last_cycle) last_grant <= acc.sel;
        end
        // A rejected misaligned access still counts as D's turn, so a
        // waiting fetch is not starved by a stream of bad D requests.
        ERR_D: last_grant <= SEL_D;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    i_done    = 1'b0;
    i_rdata   = '0;
    d_done    = 1'b0;
    d_rdata   = '0;
    d_err     = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_dump  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    // Outputs are forced quiet while reset is held so an aborted access
    // never produces a done pulse.
    if (!rst) begin
      case (state)
        IDLE: begin
          if (grant_d)      state_nxt = d_addr[0] ? ERR_D : BUSY_D;
          else if (grant_i) state_nxt = BUSY_I;
        end
        BUSY_I, BUSY_D: begin
          mem_en    = 1'b1;
          mem_addr  = acc.addr;
          mem_wdata = acc.wdata;
          mem_wr    = acc.wr   & (acc.sel == SEL_D);
          mem_dump  = acc.dump & (acc.sel == SEL_D);
          if (last_cycle) begin
            state_nxt = IDLE;
            if (state == BUSY_I) begin
              i_done  = 1'b1;
              i_rdata = mem_rdata;
            end else begin
              d_done  = 1'b1;
              d_rdata = mem_rdata;
            end
          end
        end
        ERR_D: begin
          d_done    = 1'b1;
          d_err     = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter.
// u_dut runs LATENCY=2 against a small behavioural memory; u_dut3
// (LATENCY=3) shares the request inputs and is only checked in the
// mid-access reset step.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr, d_dump;
  logic [15:0] i_addr, d_addr, d_wdata;

  logic        i_done, i_stall, d_done, d_err, d_stall;
  logic [15:0] i_rdata, d_rdata;
  logic        mem_en, mem_wr, mem_dump;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic        i_done3, i_stall3, d_done3, d_err3, d_stall3;
  logic [15:0] i_rdata3, d_rdata3;
  logic        mem_en3, mem_wr3, mem_dump3;
  logic [15:0] mem_addr3, mem_wdata3;
  logic [15:0] mem_rdata3;

  logic [15:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en)                 mem[pl_addr]        <= pl_data;
    else if (mem_en && mem_wr) mem[mem_addr[7:0]]  <= mem_wdata;
  end
  assign mem_rdata  = mem[mem_addr[7:0]];
  assign mem_rdata3 = 16'h0;

  mem_port_arbiter #(.LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_wr(d_wr), .d_dump(d_dump), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err), .d_stall(d_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_dump(mem_dump), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done3), .i_rdata(i_rdata3), .i_stall(i_stall3),
    .d_req(d_req), .d_wr(d_wr), .d_dump(d_dump), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done3), .d_rdata(d_rdata3), .d_err(d_err3), .d_stall(d_stall3),
    .mem_en(mem_en3), .mem_wr(mem_wr3), .mem_dump(mem_dump3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // start of a cycle: just after the rising edge, where inputs are driven
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // sample point: falling edge, away from the active edge
  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; d_dump = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    pl_en = 1'b1; pl_addr = 8'h10; pl_data = 16'hBEEF;
    cyc();
    pl_en = 1'b0;
    mid();
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_d_done", {31'b0, d_done}, 32'd0);
    chk("rst_i_done", {31'b0, i_done}, 32'd0);
    cyc();
    rst = 1'b0;
    mid();
    chk("idle_mem_en",  {31'b0, mem_en}, 32'd0);
    chk("idle_addr",    {16'b0, mem_addr}, 32'd0);
    chk("idle_d_stall", {31'b0, d_stall}, 32'd0);

    // ---- D read of 0x0010 (holds 0xBEEF) ----
    cyc();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0010;
    mid();
    chk("rd_c0_stall", {31'b0, d_stall}, 32'd1);
    chk("rd_c0_en",    {31'b0, mem_en}, 32'd0);
    cyc();
    d_addr = 16'h0055;  // must not disturb the latched address
    mid();
    chk("rd_c1_en",    {31'b0, mem_en}, 32'd1);
    chk("rd_c1_addr",  {16'b0, mem_addr}, 32'h0010);
    chk("rd_c1_done",  {31'b0, d_done}, 32'd0);
    chk("rd_c1_stall", {31'b0, d_stall}, 32'd1);
    chk("rd_c1_rdata", {16'b0, d_rdata}, 32'h0);
    cyc();
    mid();
    chk("rd_c2_done",  {31'b0, d_done}, 32'd1);
    chk("rd_c2_rdata", {16'b0, d_rdata}, 32'hBEEF);
    chk("rd_c2_stall", {31'b0, d_stall}, 32'd0);
    chk("rd_c2_err",   {31'b0, d_err}, 32'd0);
    cyc();
    d_req = 1'b0;
    mid();
    chk("rd_c3_en",   {31'b0, mem_en}, 32'd0);
    chk("rd_c3_done", {31'b0, d_done}, 32'd0);

    // ---- D write 0x1234 -> 0x0020, then I read 0x0020 ----
    cyc();
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
    mid();
    chk("wr_c0_stall", {31'b0, d_stall}, 32'd1);
    cyc();
    mid();
    chk("wr_c1_en",    {31'b0, mem_en}, 32'd1);
    chk("wr_c1_wr",    {31'b0, mem_wr}, 32'd1);
    chk("wr_c1_wdata", {16'b0, mem_wdata}, 32'h1234);
    cyc();
    mid();
    chk("wr_c2_done", {31'b0, d_done}, 32'd1);
    chk("wr_c2_wr",   {31'b0, mem_wr}, 32'd1);
    cyc();
    d_req = 1'b0; d_wr = 1'b0; i_req = 1'b1; i_addr = 16'h0020;
    mid();
    chk("wr_c3_idle",  {31'b0, mem_en}, 32'd0);
    chk("ir_c0_stall", {31'b0, i_stall}, 32'd1);
    cyc();
    mid();
    chk("ir_c1_en",   {31'b0, mem_en}, 32'd1);
    chk("ir_c1_wr",   {31'b0, mem_wr}, 32'd0);
    chk("ir_c1_addr", {16'b0, mem_addr}, 32'h0020);
    cyc();
    mid();
    chk("ir_c2_done",  {31'b0, i_done}, 32'd1);
    chk("ir_c2_rdata", {16'b0, i_rdata}, 32'h1234);
    chk("ir_c2_wr",    {31'b0, mem_wr}, 32'd0);
    chk("ir_c2_stall", {31'b0, i_stall}, 32'd0);
    cyc();
    i_req = 1'b0;

    // ---- both ports held from reset: D, I, D, I ----
    rst = 1'b1;
    i_req = 1'b1; i_addr = 16'h0010; d_req = 1'b1; d_addr = 16'h0020;
    mid();
    chk("tie_rst_istall", {31'b0, i_stall}, 32'd1);
    chk("tie_rst_ddone",  {31'b0, d_done}, 32'd0);
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      mid();
      chk($sformatf("tie_c%0d_ddone", k), {31'b0, d_done}, (k == 2 || k == 8) ? 32'd1 : 32'd0);
      chk($sformatf("tie_c%0d_idone", k), {31'b0, i_done}, (k == 5 || k == 11) ? 32'd1 : 32'd0);
      chk($sformatf("tie_c%0d_en", k),    {31'b0, mem_en}, (k % 3 == 0) ? 32'd0 : 32'd1);
      if (k == 2) chk("tie_d_rdata", {16'b0, d_rdata}, 32'h1234);
      if (k == 5) chk("tie_i_rdata", {16'b0, i_rdata}, 32'hBEEF);
      cyc();
    end
    i_req = 1'b0; d_req = 1'b0;
    mid();
    chk("tie_end_en", {31'b0, mem_en}, 32'd0);

    // ---- misaligned D read at 0x0011 ----
    cyc();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0011;
    mid();
    chk("mis_c0_en",    {31'b0, mem_en}, 32'd0);
    chk("mis_c0_stall", {31'b0, d_stall}, 32'd1);
    cyc();
    mid();
    chk("mis_c1_done",  {31'b0, d_done}, 32'd1);
    chk("mis_c1_err",   {31'b0, d_err}, 32'd1);
    chk("mis_c1_en",    {31'b0, mem_en}, 32'd0);
    chk("mis_c1_stall", {31'b0, d_stall}, 32'd0);
    cyc();
    d_req = 1'b0;
    mid();
    chk("mis_c2_en",  {31'b0, mem_en}, 32'd0);
    chk("mis_c2_err", {31'b0, d_err}, 32'd0);

    // ---- dump request ----
    cyc();
    d_req = 1'b1; d_dump = 1'b1; d_addr = 16'h0030;
    mid();
    chk("dmp_c0_dump", {31'b0, mem_dump}, 32'd0);
    cyc();
    mid();
    chk("dmp_c1_dump", {31'b0, mem_dump}, 32'd1);
    chk("dmp_c1_en",   {31'b0, mem_en}, 32'd1);
    chk("dmp_c1_done", {31'b0, d_done}, 32'd0);
    cyc();
    mid();
    chk("dmp_c2_dump", {31'b0, mem_dump}, 32'd1);
    chk("dmp_c2_done", {31'b0, d_done}, 32'd1);
    cyc();
    d_req = 1'b0; d_dump = 1'b0;
    mid();
    chk("dmp_c3_dump", {31'b0, mem_dump}, 32'd0);

    // ---- reset in the middle busy cycle (LATENCY=3 instance) ----
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
    mid();
    chk("r3_c0_stall", {31'b0, d_stall3}, 32'd1);
    chk("r3_c0_en",    {31'b0, mem_en3}, 32'd0);
    cyc();
    mid();
    chk("r3_c1_en",   {31'b0, mem_en3}, 32'd1);
    chk("r3_c1_done", {31'b0, d_done3}, 32'd0);
    cyc();
    rst = 1'b1;
    mid();
    chk("r3_c2_done", {31'b0, d_done3}, 32'd0);
    cyc();
    rst = 1'b0;
    mid();
    chk("r3_c3_done",  {31'b0, d_done3}, 32'd0);
    chk("r3_c3_en",    {31'b0, mem_en3}, 32'd0);
    chk("r3_c3_stall", {31'b0, d_stall3}, 32'd1);
    cyc();
    d_req = 1'b0;
    for (int k = 0; k < 6; k++) cyc();
    mid();
    chk("r3_end_en", {31'b0, mem_en3}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port 16-bit data memory between the fetch stage (read-only I-port) and the memory stage (read/write/dump D-port). It sequences each access over a fixed multi-cycle memory latency, returns read data with a one-cycle done strobe, and produces per-port stall signals for the pipeline hazard logic. It sits between the fetch/memory stages and the memory instance, which reads combinationally and writes on the clock edge.

## Interface
- LATENCY, 2: cycles the memory is held per access (1..15)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch read request; held until i_done
- i_addr  in  16  fetch address
- i_done  out  1  fetch access completes this cycle
- i_rdata  out  16  fetch read data, valid when i_done
- i_stall  out  1  i_req & ~i_done
- d_req  in  1  memory-stage request; held until d_done
- d_wr  in  1  1 = write, 0 = read
- d_dump  in  1  request memory dump (treated as a D access)
- d_addr  in  16  data address
- d_wdata  in  16  write data
- d_done  out  1  D access completes this cycle
- d_rdata  out  16  D read data, valid when d_done & ~d_wr
- d_err  out  1  with d_done: unaligned D address, access suppressed
- d_stall  out  1  d_req & ~d_done
- mem_en, mem_wr, mem_dump  out  1 each  memory controls
- mem_addr, mem_wdata  out  16 each  memory address / write data
- mem_rdata  in  16  memory read data (combinational)

## Operation
- States: IDLE, BUSY_I, BUSY_D, ERR_D.
- IDLE, no request: stay; all mem_* outputs 0.
- IDLE, one request: grant it. Both requesting: grant the port not granted last (last_grant reset to I, so D wins the first tie).
- Grant latches addr/wdata/wr/dump and port select into registers; cnt <= 0; next state BUSY_I/BUSY_D.
- D grant with d_addr[0]=1 goes to ERR_D instead: no memory access; ERR_D lasts one cycle with d_done=1, d_err=1, then IDLE.
- BUSY_x: mem_en=1; mem_addr/mem_wdata from latched regs; mem_wr = latched wr (D only); mem_dump = latched dump (D only); I accesses never assert mem_wr or mem_dump. cnt increments each cycle.
- Final busy cycle (cnt == LATENCY-1): x_done=1, x_rdata = mem_rdata (combinational pass-through); next state IDLE; last_grant <= x.
- Requester advances on the edge ending its done cycle; its req is re-evaluated only in the following IDLE cycle.
- Request inputs are ignored outside IDLE. Changing a held request's addr/data mid-access has no effect (latched).
- x_rdata = 0 when x_done=0.

## Timing
- Reset: state IDLE, cnt 0, last_grant I; all outputs 0 (stalls follow req combinationally). Reset mid-access aborts it with no done pulse. A multi-cycle write may already have committed.
- Access: request seen in IDLE cycle 0. Busy cycles 1..LATENCY. Done in cycle LATENCY. Stall high cycles 0..LATENCY-1.
- Throughput: one access per LATENCY+1 cycles. Back-to-back accesses always have one IDLE cycle between them.
- Misaligned D: granted cycle 0, d_done/d_err in cycle 1.
- Waiting port: stall stays high through the other port's entire access plus its own.
- cnt is 4 bits; LATENCY=1 gives a single busy cycle with done.

## Structure
- Shared package/include: state encodings (2-bit), port-select encoding (I=0, D=1), default LATENCY.
- One natural sub-module: mem_arb_rr, a 2-way round-robin priority picker (inputs i_req, d_req, last_grant; outputs grant_i, grant_d).
- Registers: state, cnt, last_grant, latched addr/wdata/wr/dump/sel.

## Test plan
- LATENCY=2, single D read of 0x0010 holding 0xBEEF at cycle 0: busy cycles 1–2; d_done=1 and d_rdata=0xBEEF in cycle 2; d_stall=1 in cycles 0–1.
- D write 0x1234 to 0x0020, then I read of 0x0020: write occupies cycles 1–2, IDLE in cycle 3; the I read returns 0x1234; mem_wr is never high during the I access.
- i_req and d_req both held from reset: grant order D, I, D, I, with done pulses at cycles 2, 5, 8, 11.
- D read at odd address 0x0011: d_done=1 and d_err=1 in cycle 1; mem_en=0 throughout.
- rst asserted in the middle busy cycle (LATENCY=3): next cycle in IDLE; no done pulse; mem_en=0.
- d_dump=1 request: mem_dump=1 and mem_en=1 in every busy cycle, then d_done.
